iq_capture_buffer: RTL and testbench
====================================

// Module: iq_capture_buffer
// PURPOSE
//  Sink for the overlay output streams (o_I0/Q0/I1/Q1 data+valid). Captures a programmable
//  number of strobed dual-channel IQ samples into on-chip RAM after arm+trigger, then lets a
//  host/bench read them back by address. Output-side counterpart of the strobed IQ source.
// PARAMETERS
//  DATA_W   16   width of each I/Q component (signed, two's complement)
//  ADDR_W   10   buffer address width; DEPTH = 2**ADDR_W samples (1024)
// PORTS
//  i_clk           in   1          single clock for all logic
//  i_rst           in   1          synchronous, active-high reset
//  i_I0_data       in   DATA_W     channel 0 I sample
//  i_Q0_data       in   DATA_W     channel 0 Q sample
//  i_I1_data       in   DATA_W     channel 1 I sample
//  i_Q1_data       in   DATA_W     channel 1 Q sample
//  i_I0_valid      in   1          strobes, one clk per sample
//  i_Q0_valid      in   1
//  i_I1_valid      in   1
//  i_Q1_valid      in   1
//  i_arm           in   1          pulse: start new capture (IDLE/DONE only)
//  i_abort         in   1          pulse: return to IDLE from any state
//  i_trig          in   1          level/pulse: qualifies first sample while ARMED
//  i_capture_len   in   ADDR_W+1   samples to capture; 0 or >DEPTH => DEPTH
//  i_rd_en         in   1          read request
//  i_rd_addr       in   ADDR_W     read address
//  o_rd_data       out  4*DATA_W   {Q1,I1,Q0,I0}, valid 1 clk after i_rd_en
//  o_rd_valid      out  1          high 1 clk after accepted read
//  o_busy          out  1          high in ARMED or CAPTURE
//  o_done          out  1          high in DONE
//  o_count         out  ADDR_W+1   samples written in current/last capture
//  o_valid_err     out  1          sticky: strobes disagreed during a capture
// BEHAVIOUR
//  - Reset (and i_abort): state IDLE; o_rd_data=0, o_rd_valid=0, o_busy=0, o_done=0,
//    o_count=0, o_valid_err=0. RAM contents not cleared. Reset mid-capture behaves identically.
//  - Sample strobe s = i_I0_valid & i_Q0_valid. Mismatch m = any valid differs from the
//    others; in ARMED/CAPTURE m sets o_valid_err (cleared only by reset/abort/arm).
//  - FSM:
//    IDLE    : i_arm -> ARMED; latch len_q (clamped), o_count=0, o_valid_err=0.
//    ARMED   : s & i_trig -> CAPTURE; that same sample written at addr 0, o_count=1.
//              If len_q==1 go straight to DONE instead.
//    CAPTURE : each s writes {Q1,I1,Q0,I0} at addr o_count, o_count++; on the write that
//              makes o_count==len_q -> DONE. Samples with s=0 ignored; no gaps recorded.
//    DONE    : holds; i_arm -> ARMED (new capture, overwrites from addr 0).
//  - i_arm in ARMED/CAPTURE ignored. i_abort and i_arm same cycle: abort wins.
//  - Write address wraps never: capture stops at len_q <= DEPTH.
//  - Reads: accepted only in IDLE/DONE; o_rd_data registered, latency 1, o_rd_valid pulses.
//    Reads in ARMED/CAPTURE ignored (o_rd_valid=0, o_rd_data holds). Back-to-back reads
//    every clk supported. Reading addr >= o_count returns stale RAM content, not an error.
//  - o_busy/o_done/o_count are registered, updated the clk after the causing event.
// STRUCTURE
//  - Package iq_capture_pkg: state enum {IDLE,ARMED,CAPTURE,DONE}, IQ_WORD_W = 4*DATA_W,
//    default DATA_W/ADDR_W constants.
//  - Sub-module iq_capture_ram: simple dual-port RAM, 1 write port, 1 registered read port,
//    width IQ_WORD_W, depth 2**ADDR_W, inferred BRAM.
//  - Top: FSM, length clamp, write counter, strobe check, read gating.
// TESTING
//  1 Reset: assert i_rst 2 clks mid-CAPTURE -> all outputs 0, state IDLE, next arm works.
//  2 Basic: len=8, arm, trig high, strobe every 4 clks (I0=k,Q0=-k,I1=2k,Q1=-2k, k=1..8)
//    -> o_done after 8th strobe, o_count=8, reads addr 0..7 return exact words, latency 1.
//  3 Trigger gating: armed, 5 strobes with trig=0, then trig pulse coincident with sample k=6
//    -> addr 0 holds k=6; earlier samples absent.
//  4 Length clamp: len=0 and len=2000 -> capture stops at 1024; o_count=1024; no wrap.
//  5 Valid mismatch: during capture assert i_I1_valid without others once -> o_valid_err=1,
//    capture continues; cleared by next i_arm.
//  6 Abort/arm conflict: arm+abort same clk -> IDLE; reads during CAPTURE -> o_rd_valid=0.

Source files
------------

// File: rtl/iq_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iq_capture_pkg
// Description : Shared types and constants for the IQ capture buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package iq_capture_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int IQ_WORD_W  = 4 * DATA_W_DEF;

  // Capture controller states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  // Packed {Q1,I1,Q0,I0} word width for an arbitrary component width
  function automatic int iq_word_w(input int data_w);
    return 4 * data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : iq_capture_ram
// Description : Simple dual-port sample RAM, one write port and one
//               registered read port (block-RAM inferable).
// Revision    : 1.0 - initial release
// ============================================================================
module iq_capture_ram #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:(2**ADDR_W)-1];

  // Write port: contents are never cleared
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; output register clears on reset and holds otherwise
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/iq_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : iq_capture_buffer
// Description : Arm/trigger controlled capture of strobed dual-channel IQ
//               samples into on-chip RAM with gated host read-back.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_capture_buffer
  import iq_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_W-1:0]     i_I0_data,
  input  logic [DATA_W-1:0]     i_Q0_data,
  input  logic [DATA_W-1:0]     i_I1_data,
  input  logic [DATA_W-1:0]     i_Q1_data,
  input  logic                  i_I0_valid,
  input  logic                  i_Q0_valid,
  input  logic                  i_I1_valid,
  input  logic                  i_Q1_valid,
  input  logic                  i_arm,
  input  logic                  i_abort,
  input  logic                  i_trig,
  input  logic [ADDR_W:0]       i_capture_len,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [4*DATA_W-1:0]   o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_W:0]       o_count,
  output logic                  o_valid_err
);

  localparam int             WORD_W    = 4 * DATA_W;
  localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN   = {{ADDR_W{1'b0}}, 1'b1};

  cap_state_t        state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   count_inc;
  logic              strobe;
  logic              mismatch;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_word;
  logic              rd_accept;
  logic              ram_rst;

  // Strobe, valid-agreement check, length clamp and RAM port steering
  always_comb begin
    strobe      = i_I0_valid & i_Q0_valid;
    mismatch    = (i_I0_valid | i_Q0_valid | i_I1_valid | i_Q1_valid) &
                  ~(i_I0_valid & i_Q0_valid & i_I1_valid & i_Q1_valid);
    len_clamped = ((i_capture_len == '0) || (i_capture_len > DEPTH_LEN)) ?
                  DEPTH_LEN : i_capture_len;
    count_inc   = o_count + ONE_LEN;
    // The triggering sample always lands at address 0; later ones at o_count,
    // which stays below len_q <= DEPTH so the address never wraps.
    wr_addr     = (state == ST_ARMED) ? '0 : o_count[ADDR_W-1:0];
    wr_en       = strobe & ~i_abort & ~i_rst &
                  (((state == ST_ARMED) & i_trig) | (state == ST_CAPTURE));
    wr_word     = {i_Q1_data, i_I1_data, i_Q0_data, i_I0_data};
    rd_accept   = i_rd_en & ~i_abort & ((state == ST_IDLE) | (state == ST_DONE));
    ram_rst     = i_rst | i_abort;
  end

  // Capture controller with registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      o_count     <= '0;
      o_valid_err <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rd_valid  <= 1'b0;
    end else begin
      o_rd_valid <= rd_accept;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_arm) begin
            state       <= ST_ARMED;
            len_q       <= len_clamped;
            o_count     <= '0;
            o_valid_err <= 1'b0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (mismatch) o_valid_err <= 1'b1;
          if (strobe && i_trig) begin
            o_count <= ONE_LEN;
            if (len_q == ONE_LEN) begin
              state  <= ST_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              state <= ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (mismatch) o_valid_err <= 1'b1;
          if (strobe) begin
            o_count <= count_inc;
            if (count_inc == len_q) begin
              state  <= ST_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  iq_capture_ram #(
    .WIDTH  (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (i_clk),
    .rst     (ram_rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_word),
    .rd_en   (rd_accept),
    .rd_addr (i_rd_addr),
    .rd_data (o_rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_iq_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_capture_buffer
// Description : Directed plus randomized bench for iq_capture_buffer with a
//               sample-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_capture_buffer;

  localparam int DEPTH = 1024;
  localparam int P_IDLE = 0, P_ARMED = 1, P_CAPTURE = 2, P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst, arm, abort_p, trig, rd_en;
  logic [15:0] i0_data, q0_data, i1_data, q1_data;
  logic        i0_valid, q0_valid, i1_valid, q1_valid;
  logic [10:0] cap_len;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        rd_valid, busy, done, valid_err;
  logic [10:0] count;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: phase, captured-sample count, latched length, RAM image
  int          m_phase = P_IDLE;
  int          m_cnt   = 0;
  int          m_len   = 0;
  logic        m_err   = 1'b0;
  logic [63:0] m_rd_data = '0;
  logic        m_rd_valid = 1'b0;
  logic [63:0] m_mem [0:DEPTH-1];
  int          hi_w = 0;

  always #5 clk = ~clk;

  iq_capture_buffer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_I0_data    (i0_data),
    .i_Q0_data    (q0_data),
    .i_I1_data    (i1_data),
    .i_Q1_data    (q1_data),
    .i_I0_valid   (i0_valid),
    .i_Q0_valid   (q0_valid),
    .i_I1_valid   (i1_valid),
    .i_Q1_valid   (q1_valid),
    .i_arm        (arm),
    .i_abort      (abort_p),
    .i_trig       (trig),
    .i_capture_len(cap_len),
    .i_rd_en      (rd_en),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_valid   (rd_valid),
    .o_busy       (busy),
    .o_done       (done),
    .o_count      (count),
    .o_valid_err  (valid_err)
  );

  function automatic logic [63:0] mkw(input int k);
    return {16'(-2 * k), 16'(2 * k), 16'(-k), 16'(k)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    logic [63:0] w;
    logic s, m;
    w = {q1_data, i1_data, q0_data, i0_data};
    s = i0_valid & q0_valid;
    m = (i0_valid | q0_valid | i1_valid | q1_valid) &&
        !(i0_valid & q0_valid & i1_valid & q1_valid);
    if (rst || abort_p) begin
      m_phase = P_IDLE; m_cnt = 0; m_err = 1'b0;
      m_rd_data = '0; m_rd_valid = 1'b0;
      return;
    end
    m_rd_valid = rd_en && (m_phase == P_IDLE || m_phase == P_DONE);
    if (m_rd_valid) m_rd_data = m_mem[rd_addr];
    if (m_phase == P_IDLE || m_phase == P_DONE) begin
      if (arm) begin
        m_phase = P_ARMED;
        m_len = (cap_len == 0 || int'(cap_len) > DEPTH) ? DEPTH : int'(cap_len);
        m_cnt = 0; m_err = 1'b0;
      end
    end else begin
      if (m) m_err = 1'b1;
      if (s && (m_phase == P_CAPTURE || trig)) begin
        m_mem[m_cnt] = w;
        m_cnt++;
        if (m_cnt > hi_w) hi_w = m_cnt;
        m_phase = (m_cnt == m_len) ? P_DONE : P_CAPTURE;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("rd_valid",  64'(rd_valid),  64'(m_rd_valid));
    check("rd_data",   rd_data,        m_rd_data);
    check("busy",      64'(busy),      64'(m_phase == P_ARMED || m_phase == P_CAPTURE));
    check("done",      64'(done),      64'(m_phase == P_DONE));
    check("count",     64'(count),     64'(m_cnt));
    check("valid_err", 64'(valid_err), 64'(m_err));
  endtask

  task automatic strobe_on(input logic [63:0] w);
    {q1_data, i1_data, q0_data, i0_data} = w;
    {i0_valid, q0_valid, i1_valid, q1_valid} = 4'b1111;
  endtask

  task automatic strobe_off();
    {i0_valid, q0_valid, i1_valid, q1_valid} = 4'b0000;
  endtask

  task automatic do_arm(input int len);
    cap_len = 11'(len);
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic read_at(input int a);
    rd_en = 1'b1; rd_addr = 10'(a); tick(); rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort_p = 1'b0; trig = 1'b0; rd_en = 1'b0;
    rd_addr = '0; cap_len = '0;
    i0_data = '0; q0_data = '0; i1_data = '0; q1_data = '0;
    strobe_off();
    tick(); tick();
    rst = 1'b0; tick();

    // Reset mid-capture
    do_arm(8); trig = 1'b1;
    for (int k = 1; k <= 3; k++) begin strobe_on(mkw(k)); tick(); strobe_off(); tick(); end
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_rd",    rd_data,    64'd0);

    // Basic capture, strobe every 4 clocks
    do_arm(8); trig = 1'b1;
    check("arm_busy", 64'(busy), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      strobe_on(mkw(k)); tick(); strobe_off();
      tick(); tick(); tick();
    end
    trig = 1'b0;
    check("basic_done",  64'(done),  64'd1);
    check("basic_count", 64'(count), 64'd8);
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_addr = 10'(a); tick();
      check("basic_rd_valid", 64'(rd_valid), 64'd1);
      check("basic_rd_word",  rd_data,        mkw(a + 1));
    end
    rd_en = 1'b0; tick();
    check("basic_rd_drop", 64'(rd_valid), 64'd0);

    // Trigger gating
    do_arm(4); trig = 1'b0;
    for (int k = 1; k <= 5; k++) begin strobe_on(mkw(k)); tick(); strobe_off(); tick(); end
    check("gate_count0", 64'(count), 64'd0);
    strobe_on(mkw(6)); trig = 1'b1; tick(); trig = 1'b0; strobe_off();
    for (int k = 7; k <= 9; k++) begin strobe_on(mkw(k)); tick(); strobe_off(); tick(); end
    check("gate_done", 64'(done), 64'd1);
    read_at(0); check("gate_addr0", rd_data, mkw(6));
    read_at(1); check("gate_addr1", rd_data, mkw(7));

    // Length clamp: 0 and 2000 both mean 1024
    for (int pass = 0; pass < 2; pass++) begin
      do_arm(pass == 0 ? 0 : 2000); trig = 1'b1;
      for (int n = 0; n < DEPTH + 6; n++) begin
        strobe_on({$urandom, $urandom}); tick();
      end
      strobe_off(); trig = 1'b0; tick();
      check("clamp_count", 64'(count), 64'd1024);
      check("clamp_done",  64'(done),  64'd1);
      read_at(0); read_at(1023); read_at(512);
    end

    // Valid mismatch during capture
    do_arm(16); trig = 1'b1;
    for (int k = 1; k <= 3; k++) begin strobe_on(mkw(k)); tick(); end
    strobe_off(); i1_valid = 1'b1; tick(); i1_valid = 1'b0;
    check("mism_err",   64'(valid_err), 64'd1);
    check("mism_count", 64'(count),     64'd3);
    for (int k = 4; k <= 16; k++) begin strobe_on(mkw(k)); tick(); end
    strobe_off(); trig = 1'b0; tick();
    check("mism_done",   64'(done),      64'd1);
    check("mism_sticky", 64'(valid_err), 64'd1);
    do_arm(8);
    check("mism_clear", 64'(valid_err), 64'd0);

    // Arm and abort in the same cycle: abort wins
    arm = 1'b1; abort_p = 1'b1; tick(); arm = 1'b0; abort_p = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    // Reads are ignored while capturing
    do_arm(8); trig = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      strobe_on(mkw(10 + k)); rd_en = 1'b1; rd_addr = 10'(k); tick();
      check("cap_rd_ignored", 64'(rd_valid), 64'd0);
    end
    rd_en = 1'b0; strobe_off(); trig = 1'b0;
    abort_p = 1'b1; tick(); abort_p = 1'b0;

    // Randomized traffic against the model
    for (int r = 0; r < 25; r++) begin
      do_arm($urandom_range(1, 40));
      for (int c = 0; c < 80; c++) begin
        int sel;
        sel = $urandom_range(0, 9);
        {q1_data, i1_data, q0_data, i0_data} = {$urandom, $urandom};
        if (sel < 4)       {i0_valid, q0_valid, i1_valid, q1_valid} = 4'b1111;
        else if (sel == 4) {i0_valid, q0_valid, i1_valid, q1_valid} = 4'($urandom);
        else               strobe_off();
        trig    = ($urandom_range(0, 3) != 0);
        rd_en   = $urandom_range(0, 1) == 1;
        rd_addr = 10'($urandom_range(0, hi_w - 1));
        arm     = ($urandom_range(0, 29) == 0);
        cap_len = 11'($urandom_range(0, 40));
        abort_p = ($urandom_range(0, 99) == 0);
        tick();
      end
      arm = 1'b0; abort_p = 1'b0; rd_en = 1'b0; trig = 1'b0; strobe_off();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
